// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter. Each functional unit (FU) pushes completed
//   results into its own 2-entry FIFO; every cycle at most one non-empty
//   FIFO is granted, its head is popped and registered onto the broadcast
//   bus that feeds the ROB completion inputs.
//
// Ports
//   in_clk           sole clock, rising edge
//   in_rst           synchronous reset, active low (wins over flush and pushes)
//   in_flush         discard every buffered result, reset grant pointer
//   in_fu_valid      per-FU result offer
//   out_fu_ready     per-FU accept (FIFO i holds fewer than 2 entries)
//   in_fu_value      per-FU result, FU i at [i*GPR_SIZE +: GPR_SIZE]
//   in_fu_rob_idx    per-FU destination ROB index
//   in_fu_set_nzcv   per-FU flag-write request
//   in_fu_nzcv       per-FU NZCV, FU i at [i*4 +: 4]
//   out_fu_done      one-cycle pulse per broadcast result
//   out_fu_value / out_fu_rob_idx / out_fu_set_nzcv / out_fu_nzcv
//                    broadcast payload, held while out_fu_done is low
//
// Configuration
//   CDB_ROUND_ROBIN_EN  defined: round-robin grant starting after the last
//                       granted FU. Undefined: fixed priority, lowest FU wins.

module cdb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic                             in_flush,
  input  logic [NUM_FU-1:0]                in_fu_valid,
  output logic [NUM_FU-1:0]                out_fu_ready,
  input  logic [NUM_FU*GPR_SIZE-1:0]       in_fu_value,
  input  logic [NUM_FU*ROB_IDX_SIZE-1:0]   in_fu_rob_idx,
  input  logic [NUM_FU-1:0]                in_fu_set_nzcv,
  input  logic [NUM_FU*4-1:0]              in_fu_nzcv,
  output logic                             out_fu_done,
  output logic [GPR_SIZE-1:0]              out_fu_value,
  output logic [ROB_IDX_SIZE-1:0]          out_fu_rob_idx,
  output logic                             out_fu_set_nzcv,
  output logic [3:0]                       out_fu_nzcv
);

  localparam int ENT_W = GPR_SIZE + ROB_IDX_SIZE + 5;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Entry layout: {value, rob_idx, set_nzcv, nzcv}
  logic [ENT_W-1:0]  mem_q [NUM_FU][2];
  logic [1:0]        cnt_q [NUM_FU];
  logic [NUM_FU-1:0] wr_q;
  logic [NUM_FU-1:0] rd_q;

  logic [ENT_W-1:0]  ent_in [NUM_FU];
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] nonempty;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [ENT_W-1:0]  head;

`ifdef CDB_ROUND_ROBIN_EN
  // Index where the next search starts, i.e. last granted + 1.
  logic [PTR_W-1:0]  rr_ptr_q;
`endif

  // Ready depends only on registered occupancy, never on valid or grant.
  always_comb begin
    out_fu_ready = '0;
    nonempty     = '0;
    push         = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      out_fu_ready[i] = (cnt_q[i] != 2'd2);
      nonempty[i]     = (cnt_q[i] != 2'd0);
      push[i]         = in_fu_valid[i] & out_fu_ready[i] & ~in_flush;
      ent_in[i]       = {in_fu_value[i*GPR_SIZE +: GPR_SIZE],
                         in_fu_rob_idx[i*ROB_IDX_SIZE +: ROB_IDX_SIZE],
                         in_fu_set_nzcv[i],
                         in_fu_nzcv[i*4 +: 4]};
    end
  end

  // Grant selection looks only at FIFO contents present before this edge,
  // so a result pushed now can never be broadcast in the same cycle.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef CDB_ROUND_ROBIN_EN
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
`else
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
`endif
  end

  always_comb begin
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
    head = mem_q[grant_idx][rd_q[grant_idx]];
  end

  // Payload storage is not reset; occupancy counters decide what is valid.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (in_rst && push[i]) mem_q[i][wr_q[i]] <= ent_in[i];
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= 2'd0;
      wr_q            <= '0;
      rd_q            <= '0;
      out_fu_done     <= 1'b0;
      out_fu_value    <= '0;
      out_fu_rob_idx  <= '0;
      out_fu_set_nzcv <= 1'b0;
      out_fu_nzcv     <= 4'd0;
`ifdef CDB_ROUND_ROBIN_EN
      rr_ptr_q        <= '0;
`endif
    end else if (in_flush) begin
      // Payload registers keep their last broadcast values.
      for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= 2'd0;
      wr_q        <= '0;
      rd_q        <= '0;
      out_fu_done <= 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_q[i] <= wr_q[i] ^ push[i];
        rd_q[i] <= rd_q[i] ^ pop[i];
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 2'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 2'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      out_fu_done <= grant_vld;
      if (grant_vld) begin
        {out_fu_value, out_fu_rob_idx, out_fu_set_nzcv, out_fu_nzcv} <= head;
`ifdef CDB_ROUND_ROBIN_EN
        if (int'(grant_idx) == NUM_FU - 1) rr_ptr_q <= '0;
        else                               rr_ptr_q <= grant_idx + PTR_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NUM_FU       = 4;
  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 4;

  logic                           in_clk;
  logic                           in_rst;
  logic                           in_flush;
  logic [NUM_FU-1:0]              in_fu_valid;
  logic [NUM_FU-1:0]              out_fu_ready;
  logic [NUM_FU*GPR_SIZE-1:0]     in_fu_value;
  logic [NUM_FU*ROB_IDX_SIZE-1:0] in_fu_rob_idx;
  logic [NUM_FU-1:0]              in_fu_set_nzcv;
  logic [NUM_FU*4-1:0]            in_fu_nzcv;
  logic                           out_fu_done;
  logic [GPR_SIZE-1:0]            out_fu_value;
  logic [ROB_IDX_SIZE-1:0]        out_fu_rob_idx;
  logic                           out_fu_set_nzcv;
  logic [3:0]                     out_fu_nzcv;

  int n_cmp;
  int n_err;

  cdb_arbiter #(
    .NUM_FU(NUM_FU),
    .GPR_SIZE(GPR_SIZE),
    .ROB_IDX_SIZE(ROB_IDX_SIZE)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_flush(in_flush),
    .in_fu_valid(in_fu_valid),
    .out_fu_ready(out_fu_ready),
    .in_fu_value(in_fu_value),
    .in_fu_rob_idx(in_fu_rob_idx),
    .in_fu_set_nzcv(in_fu_set_nzcv),
    .in_fu_nzcv(in_fu_nzcv),
    .out_fu_done(out_fu_done),
    .out_fu_value(out_fu_value),
    .out_fu_rob_idx(out_fu_rob_idx),
    .out_fu_set_nzcv(out_fu_set_nzcv),
    .out_fu_nzcv(out_fu_nzcv)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fu(input int i, input logic vld, input logic [63:0] v,
                          input logic [3:0] r, input logic s, input logic [3:0] nz);
    in_fu_valid[i]                        = vld;
    in_fu_value[i*GPR_SIZE +: GPR_SIZE]   = v;
    in_fu_rob_idx[i*ROB_IDX_SIZE +: ROB_IDX_SIZE] = r;
    in_fu_set_nzcv[i]                     = s;
    in_fu_nzcv[i*4 +: 4]                  = nz;
  endtask

  task automatic chk_bcast(input string tag, input logic [63:0] v, input logic [3:0] r,
                           input logic s, input logic [3:0] nz);
    chk({tag, ".done"}, 64'(out_fu_done), 64'd1);
    chk({tag, ".value"}, out_fu_value, v);
    chk({tag, ".rob"}, 64'(out_fu_rob_idx), 64'(r));
    chk({tag, ".set_nzcv"}, 64'(out_fu_set_nzcv), 64'(s));
    chk({tag, ".nzcv"}, 64'(out_fu_nzcv), 64'(nz));
  endtask

  task automatic flush_pulse();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    in_rst         = 1'b0;
    in_flush       = 1'b0;
    in_fu_valid    = '0;
    in_fu_value    = '0;
    in_fu_rob_idx  = '0;
    in_fu_set_nzcv = '0;
    in_fu_nzcv     = '0;

    // Reset values
    tick();
    tick();
    chk("rst.done", 64'(out_fu_done), 64'd0);
    chk("rst.value", out_fu_value, 64'd0);
    chk("rst.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("rst.set_nzcv", 64'(out_fu_set_nzcv), 64'd0);
    chk("rst.nzcv", 64'(out_fu_nzcv), 64'd0);
    in_rst = 1'b1;
    tick();
    chk("rst.ready", 64'(out_fu_ready), 64'hF);

    // Single result from FU2
    drive_fu(2, 1'b1, 64'h1234, 4'd5, 1'b1, 4'b0100);
    tick();
    drive_fu(2, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    chk("single.no_bypass", 64'(out_fu_done), 64'd0);
    tick();
    chk_bcast("single", 64'h1234, 4'd5, 1'b1, 4'b0100);
    tick();
    chk("single.done_low", 64'(out_fu_done), 64'd0);
    chk("single.hold_value", out_fu_value, 64'h1234);
    chk("single.hold_nzcv", 64'(out_fu_nzcv), 64'b0100);

    // Contention: all four FUs on the same edge
    flush_pulse();
    chk("flush0.done", 64'(out_fu_done), 64'd0);
    for (int i = 0; i < NUM_FU; i++)
      drive_fu(i, 1'b1, 64'hA0 + 64'(i), 4'(i), i[0], 4'(i + 8));
    tick();
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    chk("cont.first_edge", 64'(out_fu_done), 64'd0);
    tick();
    chk_bcast("cont.fu0", 64'hA0, 4'd0, 1'b0, 4'd8);
    tick();
    chk_bcast("cont.fu1", 64'hA1, 4'd1, 1'b1, 4'd9);
    tick();
    chk_bcast("cont.fu2", 64'hA2, 4'd2, 1'b0, 4'd10);
    tick();
    chk_bcast("cont.fu3", 64'hA3, 4'd3, 1'b1, 4'd11);
    tick();
    chk("cont.idle", 64'(out_fu_done), 64'd0);

    // Fairness: FU0 and FU3 offer continuously
    flush_pulse();
    drive_fu(0, 1'b1, 64'h100, 4'd0, 1'b0, 4'd0);
    drive_fu(3, 1'b1, 64'h300, 4'd3, 1'b0, 4'd0);
    tick();
    chk("fair.first_edge", 64'(out_fu_done), 64'd0);
    tick();
    chk("fair.b0.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("fair.ready3_low", 64'(out_fu_ready[3]), 64'd0);
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    chk("fair.b1.rob", 64'(out_fu_rob_idx), 64'd3);
`else
    chk("fair.b1.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("fair.ready3_stall", 64'(out_fu_ready[3]), 64'd0);
`endif
    tick();
    chk("fair.b2.rob", 64'(out_fu_rob_idx), 64'd0);
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    chk("fair.b3.rob", 64'(out_fu_rob_idx), 64'd3);
`else
    chk("fair.b3.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("fair.ready3_still", 64'(out_fu_ready[3]), 64'd0);
`endif
    chk("fair.done", 64'(out_fu_done), 64'd1);
    drive_fu(0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    drive_fu(3, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    flush_pulse();
    chk("fair.flush_ready", 64'(out_fu_ready), 64'hF);

`ifndef CDB_ROUND_ROBIN_EN
    // Backpressure: FU0 keeps the bus, FU1 pushes three results
    drive_fu(0, 1'b1, 64'h500, 4'd0, 1'b0, 4'd0);
    drive_fu(1, 1'b1, 64'h11, 4'd1, 1'b1, 4'd1);
    tick();
    chk("bp.e1.done", 64'(out_fu_done), 64'd0);
    drive_fu(1, 1'b1, 64'h12, 4'd2, 1'b1, 4'd2);
    tick();
    chk("bp.e2.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("bp.e2.ready1", 64'(out_fu_ready[1]), 64'd0);
    drive_fu(1, 1'b1, 64'h13, 4'd3, 1'b1, 4'd3);
    tick();
    chk("bp.e3.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("bp.e3.ready1", 64'(out_fu_ready[1]), 64'd0);
    tick();
    chk("bp.e4.rob", 64'(out_fu_rob_idx), 64'd0);
    drive_fu(0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    tick();
    chk_bcast("bp.e5.fu0_last", 64'h500, 4'd0, 1'b0, 4'd0);
    chk("bp.e5.ready1", 64'(out_fu_ready[1]), 64'd0);
    tick();
    chk_bcast("bp.r1", 64'h11, 4'd1, 1'b1, 4'd1);
    chk("bp.e6.ready1", 64'(out_fu_ready[1]), 64'd1);
    tick();
    chk_bcast("bp.r2", 64'h12, 4'd2, 1'b1, 4'd2);
    drive_fu(1, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    tick();
    chk_bcast("bp.r3", 64'h13, 4'd3, 1'b1, 4'd3);
    tick();
    chk("bp.idle", 64'(out_fu_done), 64'd0);
`endif

    // Flush with five results buffered
    flush_pulse();
    drive_fu(0, 1'b1, 64'hBEEF, 4'd7, 1'b1, 4'hF);
    for (int i = 1; i < NUM_FU; i++)
      drive_fu(i, 1'b1, 64'hC0 + 64'(i), 4'(i), 1'b0, 4'd0);
    tick();
    drive_fu(0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    drive_fu(3, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    tick();
    chk_bcast("fl.pre", 64'hBEEF, 4'd7, 1'b1, 4'hF);
    drive_fu(1, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    drive_fu(2, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    drive_fu(3, 1'b1, 64'hDEAD, 4'd9, 1'b0, 4'd0);
    flush_pulse();
    drive_fu(3, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    chk("fl.done", 64'(out_fu_done), 64'd0);
    chk("fl.ready", 64'(out_fu_ready), 64'hF);
    chk("fl.hold_value", out_fu_value, 64'hBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl.quiet", 64'(out_fu_done), 64'd0);
    end

    // Reset with three results buffered
    drive_fu(0, 1'b1, 64'h71, 4'd1, 1'b1, 4'd1);
    drive_fu(1, 1'b1, 64'h72, 4'd2, 1'b1, 4'd2);
    drive_fu(2, 1'b1, 64'h73, 4'd3, 1'b1, 4'd3);
    tick();
    chk("mr.first_edge", 64'(out_fu_done), 64'd0);
    for (int i = 0; i < 3; i++) drive_fu(i, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0);
    in_rst = 1'b0;
    tick();
    chk("mr.done", 64'(out_fu_done), 64'd0);
    chk("mr.value", out_fu_value, 64'd0);
    chk("mr.rob", 64'(out_fu_rob_idx), 64'd0);
    chk("mr.set_nzcv", 64'(out_fu_set_nzcv), 64'd0);
    chk("mr.nzcv", 64'(out_fu_nzcv), 64'd0);
    in_rst = 1'b1;
    tick();
    chk("mr.ready", 64'(out_fu_ready), 64'hF);
    for (int k = 0; k < 4; k++) begin
      chk("mr.quiet", 64'(out_fu_done), 64'd0);
      tick();
    end
    chk("mr.value_kept0", out_fu_value, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
